// File: rtl/max_score_tracker.sv
// Folds one (score,row,col) candidate per cycle into a running best over a sweep.
// Latency: result valid 1 cycle after the last beat is accepted.
// Backpressure: result held in HOLD until res_ready; beats arriving there are dropped and flagged.
module max_score_tracker #(
  parameter int CNT_WIDTH      = 16,
  parameter int SCORE_WIDTH    = 16,
  parameter int ROW_BITS_WIDTH = 10,
  parameter int COL_BITS_WIDTH = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      cand_valid,
  input  logic                      cand_last,
  input  logic [SCORE_WIDTH-1:0]    cand_score,
  input  logic [ROW_BITS_WIDTH-1:0] cand_row,
  input  logic [COL_BITS_WIDTH-1:0] cand_col,
  output logic                      busy,
  output logic                      cand_drop,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [SCORE_WIDTH-1:0]    res_score,
  output logic [ROW_BITS_WIDTH-1:0] res_row,
  output logic [COL_BITS_WIDTH-1:0] res_col,
  output logic [CNT_WIDTH-1:0]      res_count
);

  typedef enum logic [1:0] {IDLE, TRACK, HOLD} state_t;

  typedef struct packed {
    logic [SCORE_WIDTH-1:0]    score;
    logic [ROW_BITS_WIDTH-1:0] row;
    logic [COL_BITS_WIDTH-1:0] col;
  } cell_t;

  state_t               state;
  cell_t                best;
  logic [CNT_WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      cand_drop <= 1'b0;
      res_valid <= 1'b0;
      best      <= '0;
      count     <= '0;
    end else begin
      cand_drop <= 1'b0;
      case (state)
        IDLE: begin
          if (cand_valid) cand_drop <= 1'b1;
          if (start) begin
            state <= TRACK;
            busy  <= 1'b1;
            best  <= '0;
            count <= '0;
          end
        end
        TRACK: begin
          // A restart discards any beat presented in the same cycle.
          if (start) begin
            best  <= '0;
            count <= '0;
          end else if (cand_valid) begin
            if (count != {CNT_WIDTH{1'b1}}) count <= count + 1'b1;
            // Strict compare: ties keep the earlier (lower-index) candidate.
            if (cand_score > best.score) best <= '{cand_score, cand_row, cand_col};
            if (cand_last) begin
              state     <= HOLD;
              res_valid <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (cand_valid) cand_drop <= 1'b1;
          if (res_ready) begin
            state     <= IDLE;
            busy      <= 1'b0;
            res_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          res_valid <= 1'b0;
        end
      endcase
    end
  end

  assign res_score = best.score;
  assign res_row   = best.row;
  assign res_col   = best.col;
  assign res_count = count;

endmodule

// File: tb/tb_max_score_tracker.sv
// Randomized + directed bench for max_score_tracker with a sweep-level reference model
// and a queue scoreboard checked by an independent monitor.
module tb_max_score_tracker;

  localparam int CW   = 4;
  localparam int SW   = 8;
  localparam int RW   = 6;
  localparam int LW   = 6;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst, start, cand_valid, cand_last, res_ready;
  logic [SW-1:0] cand_score;
  logic [RW-1:0] cand_row;
  logic [LW-1:0] cand_col;
  logic          busy, cand_drop, res_valid;
  logic [SW-1:0] res_score;
  logic [RW-1:0] res_row;
  logic [LW-1:0] res_col;
  logic [CW-1:0] res_count;

  max_score_tracker #(
    .CNT_WIDTH(CW), .SCORE_WIDTH(SW), .ROW_BITS_WIDTH(RW), .COL_BITS_WIDTH(LW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cand_valid(cand_valid), .cand_last(cand_last),
    .cand_score(cand_score), .cand_row(cand_row), .cand_col(cand_col),
    .busy(busy), .cand_drop(cand_drop), .res_valid(res_valid), .res_ready(res_ready),
    .res_score(res_score), .res_row(res_row), .res_col(res_col), .res_count(res_count)
  );

  always #5 clk = ~clk;

  typedef struct {int score; int row; int col; int count;} res_t;
  typedef struct {bit busy; bit drop; bit valid; bit zero;} st_t;

  res_t rq[$];
  st_t  stq[$];
  res_t cands[$];
  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 1'b0;

  // Reference model: sweep phase, accepted beats, pending drop flag, "cleared" flag.
  int m_mode = 0;
  bit m_drop = 1'b0;
  bit m_zero = 1'b1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Result = first candidate holding the sweep maximum, or all-zero if that maximum is 0.
  function automatic res_t expect_res();
    res_t r;
    int mx;
    r = '{0, 0, 0, 0};
    mx = 0;
    foreach (cands[i]) mx = (cands[i].score > mx) ? cands[i].score : mx;
    if (mx > 0) begin
      for (int i = cands.size() - 1; i >= 0; i--)
        if (cands[i].score == mx) r = cands[i];
    end
    r.count = (cands.size() > CMAX) ? CMAX : cands.size();
    return r;
  endfunction

  task automatic step(input bit r_i, input bit st, input bit cv, input bit cl,
                      input int sc, input int rw, input int cc, input bit rdy);
    @(posedge clk);
    #1;
    stq.push_back('{m_mode != 0, m_drop, m_mode == 2, m_zero});
    rst = r_i; start = st; cand_valid = cv; cand_last = cl;
    cand_score = SW'(sc); cand_row = RW'(rw); cand_col = LW'(cc); res_ready = rdy;
    m_drop = 1'b0;
    if (r_i) begin
      m_mode = 0; cands.delete(); m_zero = 1'b1;
    end else begin
      case (m_mode)
        0: begin
          if (cv) m_drop = 1'b1;
          if (st) begin m_mode = 1; cands.delete(); m_zero = 1'b1; end
        end
        1: begin
          if (st) begin
            cands.delete(); m_zero = 1'b1;
          end else if (cv) begin
            cands.push_back('{sc, rw, cc, 0});
            m_zero = 1'b0;
            if (cl) begin rq.push_back(expect_res()); m_mode = 2; end
          end
        end
        default: begin
          if (cv) m_drop = 1'b1;
          if (rdy) m_mode = 0;
        end
      endcase
    end
  endtask

  task automatic beat(input int sc, input int rw, input int cc, input bit last);
    step(0, 0, 1, last, sc, rw, cc, 0);
  endtask

  task automatic idle(input bit rdy);
    step(0, 0, 0, 0, 0, 0, 0, rdy);
  endtask

  // Monitor: per-cycle status from the status queue; result compared while presented.
  st_t  se;
  res_t re;
  always @(negedge clk) begin
    if (mon_en) begin
      if (stq.size() > 0) begin
        se = stq.pop_front();
        chk("busy", int'(busy), int'(se.busy));
        chk("cand_drop", int'(cand_drop), int'(se.drop));
        chk("res_valid", int'(res_valid), int'(se.valid));
        if (se.zero) begin
          chk("clr_score", int'(res_score), 0);
          chk("clr_row", int'(res_row), 0);
          chk("clr_col", int'(res_col), 0);
          chk("clr_count", int'(res_count), 0);
        end
      end
      if (res_valid) begin
        if (rq.size() == 0) begin
          chk("res_unexpected", 1, 0);
        end else begin
          re = rq[0];
          chk("res_score", int'(res_score), re.score);
          chk("res_row", int'(res_row), re.row);
          chk("res_col", int'(res_col), re.col);
          chk("res_count", int'(res_count), re.count);
          if (res_ready || rst) void'(rq.pop_front());
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; start = 0; cand_valid = 0; cand_last = 0;
    cand_score = '0; cand_row = '0; cand_col = '0; res_ready = 0;
    repeat (3) @(posedge clk);
    mon_en = 1'b1;

    // Basic sweep 3,9,5(last)
    step(0, 1, 0, 0, 0, 0, 0, 0);
    beat(3, 1, 1, 0); beat(9, 2, 2, 0); beat(5, 3, 3, 1);
    idle(1); idle(0);
    // Tie keeps the earlier candidate
    step(0, 1, 0, 0, 0, 0, 0, 0);
    beat(7, 1, 1, 0); beat(7, 2, 2, 1);
    idle(1); idle(0);
    // Backpressure: start and beats during HOLD ignored / dropped
    step(0, 1, 0, 0, 0, 0, 0, 0);
    beat(11, 4, 5, 1);
    repeat (5) step(0, 1, 1, 1, 40, 9, 9, 0);
    idle(1); idle(0); idle(0);
    // Restart with same-cycle beat discarded
    step(0, 1, 0, 0, 0, 0, 0, 0);
    beat(20, 1, 1, 0); beat(30, 2, 2, 0);
    step(0, 1, 1, 0, 50, 3, 3, 0);
    beat(4, 4, 4, 1);
    idle(1); idle(0);
    // All-zero scores
    step(0, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) beat(0, i + 5, i + 6, i == 3);
    idle(1); idle(0);
    // Reset mid-sweep
    step(0, 1, 0, 0, 0, 0, 0, 0);
    beat(12, 7, 7, 0); beat(13, 8, 8, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    idle(0); idle(0);
    // Counter saturation
    step(0, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 18; i++) beat($urandom_range(0, 200), i, i + 1, i == 17);
    idle(1); idle(0);

    // Randomized sweeps
    for (int s = 0; s < 40; s++) begin
      int nb;
      nb = $urandom_range(1, 20);
      step(0, 1, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 15),
           $urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 1));
      for (int b = 0; b < nb; b++) begin
        while ($urandom_range(0, 3) == 0)
          step(0, 0, 0, $urandom_range(0, 1), $urandom_range(0, 15),
               $urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 1));
        if ($urandom_range(0, 24) == 0)
          step(0, 1, 1, $urandom_range(0, 1), $urandom_range(0, 15),
               $urandom_range(0, 63), $urandom_range(0, 63), 0);
        if ($urandom_range(0, 59) == 0)
          step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, b == nb - 1, $urandom_range(0, 15),
             $urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 1));
      end
      for (int h = 0; m_mode == 2; h++)
        step($urandom_range(0, 39) == 0, $urandom_range(0, 1), $urandom_range(0, 1),
             $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 63),
             $urandom_range(0, 63), (h > 50) || ($urandom_range(0, 2) == 0));
      repeat ($urandom_range(0, 3))
        step(0, 0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 15),
             0, 0, $urandom_range(0, 1));
    end

    idle(0); idle(0);
    @(negedge clk);
    @(posedge clk);
    chk("rq_drained", rq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
